// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU/MDU: funct codes and control states.
package alu_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mdu(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up folded into the last step.
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run_q, div_q, negp_q, negr_q;
    logic [WIDTH-1:0] ma_q, mb_q, hi_q, lo_q;
    logic [WIDTH-1:0] hi_d, lo_d, ma_d, mb_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   msum, rsh, rdiff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic             sa, sb;

    assign sa   = is_signed_i & a_i[WIDTH-1];
    assign sb   = is_signed_i & b_i[WIDTH-1];
    assign ma_d = sa ? -a_i : a_i;
    assign mb_d = sb ? -b_i : b_i;

    // Multiply keeps the multiplier in lo and accumulates into hi;
    // divide shifts the dividend out of lo while quotient bits shift in.
    always_comb begin
        msum  = {1'b0, hi_q} + {1'b0, ma_q & {WIDTH{lo_q[0]}}};
        rsh   = {hi_q, lo_q[WIDTH-1]};
        rdiff = rsh - {1'b0, mb_q};
        if (div_q) begin
            if (!rdiff[WIDTH]) begin
                hi_d = rdiff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rsh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {msum, lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {hi_d, lo_d};
        prod_fix = negp_q ? -prod : prod;
        if (div_q) begin
            lo_o = (mb_q == '0) ? '1 : (negp_q ? -lo_d : lo_d);
            hi_o = negr_q ? -hi_d : hi_d;
        end else begin
            {hi_o, lo_o} = prod_fix;
        end
    end

    assign done_o = run_q && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            negp_q <= 1'b0;
            negr_q <= 1'b0;
            ma_q   <= '0;
            mb_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            div_q  <= is_div_i;
            negp_q <= sa ^ sb;
            negr_q <= sa;
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            hi_q   <= '0;
            lo_q   <= is_div_i ? ma_d : mb_d;
            cnt_q  <= '0;
        end else if (run_q) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with handshaked issue/result and iterative mult/div into HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   rd,
    output logic               zflag
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rd_q, rd_d, hi_q, hi_d, lo_q, lo_d, alu_res;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             zf_q, zf_d, it_done, it_start;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign rd        = rd_q;
    assign zflag     = zf_q;
    assign it_start  = in_valid && in_ready && is_mdu(funct);

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (it_start),
        .is_div_i    (funct[1]),
        .is_signed_i (~funct[0]),
        .a_i         (rs),
        .b_i         (rt),
        .done_o      (it_done),
        .hi_o        (it_hi),
        .lo_o        (it_lo)
    );

    always_comb begin
        alu_res = '0;
        case (funct)
            F_ADD:  alu_res = rs + rt;
            F_SUB:  alu_res = rs - rt;
            F_AND:  alu_res = rs & rt;
            F_OR:   alu_res = rs | rt;
            F_XOR:  alu_res = rs ^ rt;
            F_NOR:  alu_res = ~(rs | rt);
            F_SLL:  alu_res = rs << shamt;
            F_SRL:  alu_res = rs >> shamt;
            F_SRA:  alu_res = $unsigned($signed(rs) >>> shamt);
            F_SLLV: alu_res = rt << rs[SHAMT_W-1:0];
            F_SRLV: alu_res = rt >> rs[SHAMT_W-1:0];
            F_SRAV: alu_res = $unsigned($signed(rt) >>> rs[SHAMT_W-1:0]);
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
            F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, rs < rt};
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        zf_d    = zf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (in_valid) begin
                if (is_mdu(funct)) begin
                    state_d = BUSY;
                end else begin
                    state_d = DONE;
                    rd_d    = alu_res;
                    zf_d    = (alu_res == '0);
                end
            end
            BUSY: if (it_done) begin
                state_d = DONE;
                hi_d    = it_hi;
                lo_d    = it_lo;
                rd_d    = it_lo;
                zf_d    = (it_lo == '0);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            zf_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            zf_q    <= zf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd;
    logic        zflag;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .shamt     (shamt),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .zflag     (zflag)
    );

    task automatic run_op(input string nm, input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output int lat);
        @(negedge clk);
        funct = f; shamt = sh; rs = a; rt = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: out_valid=%b required 1", nm, out_valid);
        end
        r = rd;
        z = zflag;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic z; int lat;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, rd, zflag} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b rd=%h zflag=%b required 1 0 00000000 0",
                     in_ready, out_valid, rd, zflag);
        end
        rst = 1'b0;
        run_op("reset_mfhi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mfhi: rd=%h required 00000000", r);
        end
    endtask

    task automatic test_add_hold();
        @(negedge clk);
        funct = F_ADD; rs = 32'hFFFFFFFF; rt = 32'h1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; funct = F_SUB; rs = 32'h5; rt = 32'h3;
        @(negedge clk);
        vectors++;
        if ({out_valid, rd, zflag} !== {1'b1, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_wrap: out_valid=%b rd=%h zflag=%b required 1 00000000 1", out_valid, rd, zflag);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, rd, zflag} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
                miscompares++;
                $display("FAIL add_hold[%0d]: out_valid=%b in_ready=%b rd=%h zflag=%b required 1 0 00000000 1",
                         i, out_valid, in_ready, rd, zflag);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_ops();
        vec_t tbl[15];
        logic [31:0] r; logic z; int lat;
        tbl[0]  = '{F_SUB,  5'd0, 32'd5,        32'd7,        32'hFFFFFFFE};
        tbl[1]  = '{F_AND,  5'd0, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200};
        tbl[2]  = '{F_OR,   5'd0, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34};
        tbl[3]  = '{F_XOR,  5'd0, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34};
        tbl[4]  = '{F_NOR,  5'd0, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB};
        tbl[5]  = '{F_SLL,  5'd8, 32'h00ABCDEF, 32'h0,        32'hABCDEF00};
        tbl[6]  = '{F_SRL,  5'd4, 32'h80000000, 32'h0,        32'h08000000};
        tbl[7]  = '{F_SRA,  5'd4, 32'h80000000, 32'h0,        32'hF8000000};
        tbl[8]  = '{F_SRAV, 5'd0, 32'd36,       32'h80000000, 32'hF8000000};
        tbl[9]  = '{F_SLLV, 5'd0, 32'd33,       32'h3,        32'h00000006};
        tbl[10] = '{F_SRLV, 5'd0, 32'd31,       32'h80000000, 32'h00000001};
        tbl[11] = '{F_SLT,  5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000001};
        tbl[12] = '{F_SLTU, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000000};
        tbl[13] = '{F_SLT,  5'd0, 32'h1,        32'hFFFFFFFF, 32'h00000000};
        tbl[14] = '{6'b111111, 5'd0, 32'h5,     32'h9,        32'h00000000};
        for (int i = 0; i < 15; i++) begin
            run_op("single", tbl[i].f, tbl[i].sh, tbl[i].a, tbl[i].b, r, z, lat);
            vectors++;
            if (r !== tbl[i].e || z !== (tbl[i].e == 32'h0) || lat != 1) begin
                miscompares++;
                $display("FAIL single[%0d] funct=%b: rd=%h zflag=%b lat=%0d required %h %b 1",
                         i, tbl[i].f, r, z, lat, tbl[i].e, (tbl[i].e == 32'h0));
            end
        end
    endtask

    task automatic test_mult();
        logic [31:0] r; logic z; int lat;
        run_op("mult", F_MULT, 5'd0, 32'hFFFFFFFD, 32'd7, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFEB || lat != 33) begin
            miscompares++;
            $display("FAIL mult: rd=%h lat=%0d required FFFFFFEB 33", r, lat);
        end
        run_op("mult_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL mult_hi: rd=%h required FFFFFFFF", r);
        end
        run_op("multu", F_MULTU, 5'd0, 32'hFFFFFFFD, 32'd7, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFEB || lat != 33) begin
            miscompares++;
            $display("FAIL multu: rd=%h lat=%0d required FFFFFFEB 33", r, lat);
        end
        run_op("multu_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h00000006) begin
            miscompares++;
            $display("FAIL multu_hi: rd=%h required 00000006", r);
        end
        run_op("multu_lo", F_MFLO, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL multu_lo: rd=%h required FFFFFFEB", r);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic z; int lat;
        @(negedge clk);
        funct = F_MULT; rs = 32'hFFFFFFFD; rt = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("mid_reset_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_hi: rd=%h required 00000000", r);
        end
        run_op("mid_reset_lo", F_MFLO, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h0 || z !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_lo: rd=%h zflag=%b required 00000000 1", r, z);
        end
    endtask

    task automatic test_div();
        logic [31:0] r; logic z; int lat;
        run_op("div", F_DIV, 5'd0, 32'hFFFFFFF9, 32'd2, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFFD || lat != 33) begin
            miscompares++;
            $display("FAIL div: rd=%h lat=%0d required FFFFFFFD 33", r, lat);
        end
        run_op("div_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL div_hi: rd=%h required FFFFFFFF", r);
        end
        run_op("divu_zero", F_DIVU, 5'd0, 32'd7, 32'd0, r, z, lat);
        vectors++;
        if (r !== 32'hFFFFFFFF || lat != 33) begin
            miscompares++;
            $display("FAIL divu_zero: rd=%h lat=%0d required FFFFFFFF 33", r, lat);
        end
        run_op("divu_zero_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h00000007) begin
            miscompares++;
            $display("FAIL divu_zero_hi: rd=%h required 00000007", r);
        end
        run_op("div_min", F_DIV, 5'd0, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
        vectors++;
        if (r !== 32'h80000000) begin
            miscompares++;
            $display("FAIL div_min: rd=%h required 80000000", r);
        end
        run_op("div_min_hi", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'h0 || z !== 1'b1) begin
            miscompares++;
            $display("FAIL div_min_hi: rd=%h zflag=%b required 00000000 1", r, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic z; int lat;
        int busy_hits = 0;
        int n = 0;
        @(negedge clk);
        funct = F_DIVU; rs = 32'd100; rt = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 funct = F_ADD; rs = 32'd1; rt = 32'd1;
        do begin
            @(negedge clk);
            n++;
            if (in_ready !== 1'b0) busy_hits++;
        end while (!out_valid && n < 100);
        vectors++;
        if (busy_hits != 0 || out_valid !== 1'b1 || rd !== 32'd14) begin
            miscompares++;
            $display("FAIL busy_hold: in_ready_high_cycles=%0d out_valid=%b rd=%h required 0 1 0000000e",
                     busy_hits, out_valid, rd);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL no_second_accept: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        run_op("busy_rem", F_MFHI, 5'd0, 32'h0, 32'h0, r, z, lat);
        vectors++;
        if (r !== 32'd2) begin
            miscompares++;
            $display("FAIL busy_rem: rd=%h required 00000002", r);
        end
    endtask

    initial begin
        test_reset();
        test_add_hold();
        test_single_ops();
        test_mult();
        test_reset_mid_op();
        test_div();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
